// File: rtl/assign_pipe_pkg.sv
// Shared op encoding and per-bit op evaluation for the registered assignment pipe.
package assign_pipe_pkg;

  typedef enum logic [1:0] {
    PASS_A = 2'b00,
    PASS_B = 2'b01,
    AND_OP = 2'b10,
    XOR_OP = 2'b11
  } op_e;

  // Evaluated one bit at a time so callers of any width can use it without truncation.
  function automatic logic apply_op(input logic a, input logic b, input op_e op);
    logic r;
    case (op)
      PASS_A:  r = a;
      PASS_B:  r = b;
      AND_OP:  r = a & b;
      XOR_OP:  r = a ^ b;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/assign_pipe_stage.sv
// One elastic valid/data register: loads upstream on i_load, otherwise holds.
// Data is written only for a valid upstream beat so an idle stage keeps its last result.
module pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/assign_pipe.sv
// Bitwise op (A, B, AND, XOR) into a DEPTH-stage elastic pipe; DEPTH cycles latency unstalled.
// Full pipe with out_ready low drops in_ready combinationally; delivered results are counted.
module assign_pipe
  import assign_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count
);

  if (DEPTH < 1) begin : g_bad_depth
    $error("assign_pipe: DEPTH must be at least 1");
  end

  logic [WIDTH-1:0] w_op_data;
  logic [DEPTH-1:0] w_valid;
  logic [WIDTH-1:0] w_data [DEPTH];
  logic [CNT_W-1:0] r_count;

  always_comb begin
    w_op_data = '0;
    for (int j = 0; j < WIDTH; j++) begin
      w_op_data[j] = apply_op(in_a[j], in_b[j], op_e'(in_op));
    end
  end

  // Ready ripples back from the consumer; a stage accepts whenever it is empty or draining.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             w_rdy;
    logic             w_up_valid;
    logic [WIDTH-1:0] w_up_data;

    if (i == 0) begin : g_head
      assign w_up_valid = in_valid;
      assign w_up_data  = w_op_data;
    end else begin : g_body
      assign w_up_valid = w_valid[i-1];
      assign w_up_data  = w_data[i-1];
    end

    if (i == DEPTH - 1) begin : g_last
      assign w_rdy = !w_valid[i] || out_ready;
    end else begin : g_mid
      assign w_rdy = !w_valid[i] || g_stage[i+1].w_rdy;
    end

    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_rdy),
      .i_valid (w_up_valid),
      .i_data  (w_up_data),
      .o_valid (w_valid[i]),
      .o_data  (w_data[i])
    );
  end

  assign in_ready  = g_stage[0].w_rdy;
  assign out_valid = w_valid[DEPTH-1];
  assign out_data  = w_data[DEPTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (out_valid && out_ready) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign out_count = r_count;

endmodule

// File: tb/tb_assign_pipe.sv
// Randomized and directed bench for assign_pipe with an in-order scoreboard model.
module tb_assign_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic [1:0]       in_op = 2'b00;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] out_count;

  int tests = 0;
  int failed = 0;
  int cyc = 0;

  assign_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic [1:0] op);
    case (op)
      2'd0:    return a;
      2'd1:    return b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  // Model: in-flight results in order, each stamped with its accept cycle.
  // The oldest result never waits on anything but the consumer, so it is visible
  // from accept_cycle + DEPTH onwards; the pipe is full exactly when DEPTH are in flight.
  typedef struct {
    logic [WIDTH-1:0] d;
    int               t;
  } item_t;

  item_t q[$];
  int    m_count = 0;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_count = 0;
      if (clk == 1'b0) begin
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
      end
    end else begin
      automatic int   cur = cyc;
      automatic logic exp_rdy = (q.size() < DEPTH) || out_ready;
      automatic logic exp_vld = (q.size() > 0) && (cur >= q[0].t + DEPTH);
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(exp_vld));
      if (exp_vld && out_valid) chk("out_data", 32'(out_data), 32'(q[0].d));
      chk("out_count", 32'(out_count), 32'(m_count % (1 << CNT_W)));
      if (exp_vld && out_ready) begin
        void'(q.pop_front());
        m_count++;
      end
      if (in_valid && exp_rdy) q.push_back('{d: ref_op(in_a, in_b, in_op), t: cur});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int n;
    logic done;

    // Reset held with a producer already pushing.
    in_valid = 1'b1; in_a = 8'hAA; in_b = 8'h55; out_ready = 1'b1;
    repeat (3) step();
    chk("t1_valid", 32'(out_valid), 32'd0);
    chk("t1_data", 32'(out_data), 32'd0);
    chk("t1_count", 32'(out_count), 32'd0);

    // All four ops back-to-back; results land DEPTH cycles after each input.
    step();
    rst_n = 1'b1; in_a = 8'hF0; in_b = 8'h3C; in_op = 2'd0;
    step(); chk("t2_lat", 32'(out_valid), 32'd0); in_op = 2'd1;
    step(); chk("t2_pass_a", 32'(out_data), 32'hF0); in_op = 2'd2;
    step(); chk("t2_pass_b", 32'(out_data), 32'h3C); in_op = 2'd3;
    step(); chk("t2_and", 32'(out_data), 32'h30); in_valid = 1'b0;
    step(); chk("t2_xor", 32'(out_data), 32'hCC);
    step(); chk("t2_count", 32'(out_count), 32'd4);

    // Backpressure: only DEPTH of five are taken while the consumer stalls.
    out_ready = 1'b0; acc = 0; in_op = 2'd3; in_b = 8'h0F;
    for (int j = 0; j < 5; j++) begin
      in_valid = 1'b1; in_a = 8'(8'h10 + acc);
      #1;
      if (j == 2) chk("t3_rdy_low", 32'(in_ready), 32'd0);
      if (in_ready) acc++;
      step();
    end
    chk("t3_accepted", 32'(acc), 32'd2);
    chk("t3_hold", 32'(out_data), 32'h1F);
    out_ready = 1'b1;
    for (int j = 0; j < 40 && acc < 5; j++) begin
      in_valid = 1'b1; in_a = 8'(8'h10 + acc);
      #1;
      if (in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    chk("t3_all_sent", 32'(acc), 32'd5);
    repeat (4) step();
    chk("t3_count", 32'(out_count), 32'd9);

    // Full pipe with both sides active keeps streaming at one per cycle.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int j = 0; j < 2; j++) begin
      in_a = 8'($urandom); in_b = 8'($urandom); in_op = 2'($urandom);
      step();
    end
    out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      in_a = 8'($urandom); in_b = 8'($urandom); in_op = 2'($urandom);
      #1;
      chk("t4_rdy", 32'(in_ready), 32'd1);
      chk("t4_vld", 32'(out_valid), 32'd1);
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();
    chk("t4_count", 32'(out_count), 32'd3);

    // Asynchronous reset with two results in flight.
    out_ready = 1'b0; in_valid = 1'b1; in_a = 8'h77; in_op = 2'd0;
    step(); step();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_vld_drop", 32'(out_valid), 32'd0);
    chk("t5_count", 32'(out_count), 32'd0);
    #4 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) step();
    chk("t5_no_stale", 32'(out_valid), 32'd0);

    // Counter wrap: 15, then 0, then 1.
    n = 0; done = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      in_a = 8'($urandom); in_b = 8'($urandom); in_op = 2'($urandom);
      if (n == 15) chk("t6_cnt15", 32'(out_count), 32'd15);
      if (n == 16) chk("t6_cnt0", 32'(out_count), 32'd0);
      if (n == 17) begin
        chk("t6_cnt1", 32'(out_count), 32'd1);
        done = 1'b1;
      end
      if (out_valid && out_ready) n++;
      step();
    end
    chk("t6_done", 32'(done), 32'd1);
    in_valid = 1'b0;
    repeat (4) step();

    // Random traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      in_valid  = ($urandom_range(99) < 70);
      out_ready = ($urandom_range(99) < 60);
      in_a  = 8'($urandom);
      in_b  = 8'($urandom);
      in_op = 2'($urandom);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) step();
    chk("drain_vld", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
